stage_id: RTL and testbench
===========================

# stage_id

Instruction-decode stage of the in-order RV64I pipeline, directly downstream of instruction fetch. It holds the IF/ID pipeline register and decodes the latched instruction into immediates and control. It drives combinational register-file read addresses and returns operand values to EXE. It detects load-use hazards against EXE and produces the PC stall that holds fetch.

## Interface
- `NOP_INSTR`, default `32'h0000_0013`: bubble encoding (`addi x0,x0,0`).
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `if_pc` in 64: PC of the instruction currently presented by fetch.
- `if_instr` in 32: instruction word aligned with `if_pc`.
- `if_ready` in 1: fetch output is valid this cycle.
- `exe_redirect` in 1: EXE taken branch/jump; flush.
- `exe_valid` in 1: EXE holds a real instruction.
- `exe_is_load` in 1: EXE instruction is a load.
- `exe_rd` in 5: EXE destination register.
- `exe_stall` in 1: downstream cannot accept this cycle.
- `rf_raddr1`, `rf_raddr2` out 5: register-file read addresses (combinational).
- `rf_rdata1`, `rf_rdata2` in 64: same-cycle read data (x0 reads 0).
- `id_stall` out 1: to fetch PC stall input.
- `id_valid` out 1: decode outputs carry a real instruction.
- `id_pc` out 64, `id_instr` out 32: latched PC and instruction.
- `id_rs1_val`, `id_rs2_val` out 64: operands.
- `id_imm` out 64: sign-extended immediate.
- `id_rd` out 5: destination, 0 when no writeback.
- `id_funct3` out 3, `id_funct7_5` out 1: ALU selector fields.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`, `id_jump`, `id_word`, `id_alu_imm`, `id_illegal` out 1 each: control.

## Operation
- **State:** `valid_q`, `pc_q`, `instr_q`.
- **Register update priority, each edge:**
  1. `!rst`: `valid_q=0`, `pc_q=0`, `instr_q=NOP_INSTR`.
  2. `exe_redirect`: `valid_q=0`, `instr_q=NOP_INSTR`, `pc_q` unchanged. Flush beats every stall.
  3. `hold = exe_stall | load_use`: all registers keep their value.
  4. Otherwise capture `if_ready`, `if_pc`, `if_instr`.
- **Decode** (from `instr_q`, by `opcode[6:0]`):
  - LUI 0110111 and AUIPC 0010111: U-type.
  - JAL 1101111: J-type. JALR 1100111: I-type.
  - BRANCH 1100011: B-type.
  - LOAD 0000011: I-type. STORE 0100011: S-type.
  - OP-IMM 0010011 and OP-IMM-32 0011011: I-type.
  - OP 0110011 and OP-32 0111011: R-type.
  - MISC-MEM 0001111: treated as NOP.
  - SYSTEM 1110011: `id_illegal=1` (trap handled later).
- **Illegal:** any other opcode, or `instr[1:0]!=2'b11`, sets `id_illegal=1`, `id_reg_write=0`, `id_mem_*=0`.
- **Immediates:** all sign-extended from `instr[31]` to 64 bits. U immediate = `{instr[31:12],12'b0}` sign-extended. B and J immediates have bit 0 = 0.
- **Register-use rules:**
  - `uses_rs1`: all formats except U and J.
  - `uses_rs2`: R, S and B formats.
  - `rf_raddr1` / `rf_raddr2` are `instr_q[19:15]` / `instr_q[24:20]` when used, else 0.
- `id_rd = instr_q[11:7]` for formats that write (R, I, U, J). It is forced to 0 for S, B, MISC-MEM, SYSTEM and illegal. `id_reg_write = (id_rd!=0)`.
- `id_word`: set for OP-32 and OP-IMM-32. `id_alu_imm`: set for I, U and S formats.
- **load_use** = `valid_q & exe_valid & exe_is_load & exe_rd!=0` AND (`uses_rs1 & rs1==exe_rd` OR `uses_rs2 & rs2==exe_rd`).
- **Outputs:**
  - `id_stall = hold & !exe_redirect`.
  - `id_valid = valid_q & !load_use & !exe_redirect`. On a load-use cycle EXE receives a bubble and all `id_*` enables are gated to 0.
  - When `id_valid=0`, all control enables read 0 regardless of `instr_q`.

## Timing
- **Reset values:** `id_valid=0`, `id_stall=0`, `id_pc=0`, `id_instr=NOP_INSTR`, all enables 0, `id_imm=0`, `id_rd=0`.
- **Latency:** 1 cycle. An instruction presented by IF at edge N appears on `id_*` after edge N+1.
- **Load-use:** stalls exactly 1 cycle. The next cycle EXE holds the bubble, so `load_use` clears.
- **`exe_stall`:** holds the stage for as many cycles as it is asserted. `id_valid` stays unchanged.
- **Flush vs. fetch:** the redirect edge discards the wrong-path instruction fetch presents that cycle. The first redirected-path instruction is captured one edge later.
- **Reset release:** the first capture happens at the first edge with `rst=1`.

## Test plan
- **Reset:** hold `rst=0` 3 cycles with random inputs -> `id_valid=0`, `id_stall=0`, `id_instr=32'h13`. Release with `if_pc=0x80000000`, `if_instr=0xFFF00093` (`addi x1,x0,-1`) -> next cycle `id_valid=1`, `id_imm=64'hFFFF_FFFF_FFFF_FFFF`, `id_rd=1`, `id_reg_write=1`.
- **Load-use:** latched `add x3,x1,x2` with EXE `exe_valid=1`, `exe_is_load=1`, `exe_rd=2` -> `id_stall=1`, `id_valid=0` for 1 cycle. After EXE clears: `id_valid=1`, `id_stall=0`, same `id_pc`.
- **x0 and no-use:** `exe_rd=0` load, or a LUI in ID with matching rs fields -> no stall.
- **Flush priority:** `exe_redirect=1` together with `exe_stall=1` -> `id_stall=0`, `id_valid=0`. The next cycle `id_instr=32'h13`, `id_valid=0`.
- **Immediates:**
  - `beq` encoding `0xFE000EE3` -> `id_imm=-4`, `id_branch=1`, `id_rd=0`.
  - `sd x5,-8(x2)` = `0xFE513C23` -> `id_imm=-8`, `id_mem_write=1`.
  - `jal x1,+2048` = `0x001000EF` -> `id_imm=2048`.
- **Illegal:** `if_instr=0x00000000` -> `id_illegal=1`, `id_reg_write=0`, `id_mem_read=0`. `ecall` `0x00000073` -> `id_illegal=1`.

Source files
------------

// File: rtl/stage_id_if.sv
// Signal bundle between the decode stage and its neighbours: fetch inputs,
// EXE hazard/flush inputs, register-file read port and decoded outputs.
interface stage_id_if;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        exe_redirect;
    logic        exe_valid;
    logic        exe_is_load;
    logic [4:0]  exe_rd;
    logic        exe_stall;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [63:0] rf_rdata1;
    logic [63:0] rf_rdata2;
    logic        id_stall;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic [63:0] id_rs1_val;
    logic [63:0] id_rs2_val;
    logic [63:0] id_imm;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7_5;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_branch;
    logic        id_jump;
    logic        id_word;
    logic        id_alu_imm;
    logic        id_illegal;

    modport master (
        output if_pc, if_instr, if_ready, exe_redirect, exe_valid, exe_is_load,
               exe_rd, exe_stall, rf_rdata1, rf_rdata2,
        input  rf_raddr1, rf_raddr2, id_stall, id_valid, id_pc, id_instr,
               id_rs1_val, id_rs2_val, id_imm, id_rd, id_funct3, id_funct7_5,
               id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump,
               id_word, id_alu_imm, id_illegal
    );

    modport slave (
        input  if_pc, if_instr, if_ready, exe_redirect, exe_valid, exe_is_load,
               exe_rd, exe_stall, rf_rdata1, rf_rdata2,
        output rf_raddr1, rf_raddr2, id_stall, id_valid, id_pc, id_instr,
               id_rs1_val, id_rs2_val, id_imm, id_rd, id_funct3, id_funct7_5,
               id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump,
               id_word, id_alu_imm, id_illegal
    );
endinterface

// File: rtl/stage_id.sv
// RV64I instruction-decode stage: IF/ID register, immediate/control decode,
// register-file addressing and load-use hazard stall generation.
module stage_id #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic     clk,
    input logic     rst,
    stage_id_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    logic        valid_q;
    logic [63:0] pc_q;
    logic [31:0] instr_q;

    fmt_e        fmt;
    logic        illegal;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        is_word;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic [63:0] imm;
    logic        load_use;
    logic        hold;
    logic        en;

    // Opcodes whose low two bits are not 2'b11 never match and fall to illegal.
    always_comb begin
        fmt       = FMT_NONE;
        illegal   = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_word   = 1'b0;
        case (instr_q[6:0])
            7'b0110111, 7'b0010111: fmt = FMT_U;
            7'b1101111: begin fmt = FMT_J; is_jump = 1'b1; end
            7'b1100111: begin fmt = FMT_I; is_jump = 1'b1; end
            7'b1100011: begin fmt = FMT_B; is_branch = 1'b1; end
            7'b0000011: begin fmt = FMT_I; is_load = 1'b1; end
            7'b0100011: begin fmt = FMT_S; is_store = 1'b1; end
            7'b0010011: fmt = FMT_I;
            7'b0011011: begin fmt = FMT_I; is_word = 1'b1; end
            7'b0110011: fmt = FMT_R;
            7'b0111011: begin fmt = FMT_R; is_word = 1'b1; end
            7'b0001111: fmt = FMT_NONE;
            default:    illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = {{52{instr_q[31]}}, instr_q[31:20]};
            FMT_S: imm = {{52{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            FMT_B: imm = {{51{instr_q[31]}}, instr_q[31], instr_q[7],
                          instr_q[30:25], instr_q[11:8], 1'b0};
            FMT_U: imm = {{32{instr_q[31]}}, instr_q[31:12], 12'b0};
            FMT_J: imm = {{43{instr_q[31]}}, instr_q[31], instr_q[19:12],
                          instr_q[20], instr_q[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign uses_rs1  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    assign uses_rs2  = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    assign writes_rd = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);

    assign load_use = valid_q && bus.exe_valid && bus.exe_is_load && (bus.exe_rd != 5'd0) &&
                      ((uses_rs1 && (instr_q[19:15] == bus.exe_rd)) ||
                       (uses_rs2 && (instr_q[24:20] == bus.exe_rd)));
    assign hold = bus.exe_stall || load_use;
    assign en   = valid_q && !load_use && !bus.exe_redirect;

    // Flush wins over any stall; a held stage keeps pc/instr/valid untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (bus.exe_redirect) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (!hold) begin
            valid_q <= bus.if_ready;
            pc_q    <= bus.if_pc;
            instr_q <= bus.if_instr;
        end
    end

    assign bus.rf_raddr1 = uses_rs1 ? instr_q[19:15] : 5'd0;
    assign bus.rf_raddr2 = uses_rs2 ? instr_q[24:20] : 5'd0;

    // Nothing is held while reset is asserted, so fetch is never stalled then.
    assign bus.id_stall     = rst && hold && !bus.exe_redirect;
    assign bus.id_valid     = en;
    assign bus.id_pc        = pc_q;
    assign bus.id_instr     = instr_q;
    assign bus.id_rs1_val   = bus.rf_rdata1;
    assign bus.id_rs2_val   = bus.rf_rdata2;
    assign bus.id_imm       = imm;
    assign bus.id_rd        = (en && writes_rd) ? instr_q[11:7] : 5'd0;
    assign bus.id_funct3    = instr_q[14:12];
    assign bus.id_funct7_5  = instr_q[30];
    assign bus.id_reg_write = (bus.id_rd != 5'd0);
    assign bus.id_mem_read  = en && is_load;
    assign bus.id_mem_write = en && is_store;
    assign bus.id_branch    = en && is_branch;
    assign bus.id_jump      = en && is_jump;
    assign bus.id_word      = en && is_word;
    assign bus.id_alu_imm   = en && ((fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_S));
    assign bus.id_illegal   = en && illegal;
endmodule

// File: tb/tb_stage_id.sv
// Self-checking bench for stage_id: directed literal checks followed by
// randomized traffic compared every cycle against a behavioural decode model.
module tb_stage_id;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int F_NONE = 0, F_R = 1, F_I = 2, F_S = 3, F_B = 4, F_U = 5, F_J = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    stage_id_if bus();

    stage_id #(.NOP_INSTR(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [63:0] regs [32];
    assign bus.rf_rdata1 = regs[bus.rf_raddr1];
    assign bus.rf_rdata2 = regs[bus.rf_raddr2];

    logic        m_valid;
    logic [63:0] m_pc;
    logic [31:0] m_instr;

    function automatic int fmtOf(input logic [31:0] i);
        case (i[6:0])
            7'h37, 7'h17:               return F_U;
            7'h6F:                      return F_J;
            7'h67, 7'h03, 7'h13, 7'h1B: return F_I;
            7'h63:                      return F_B;
            7'h23:                      return F_S;
            7'h33, 7'h3B:               return F_R;
            default:                    return F_NONE;
        endcase
    endfunction

    function automatic bit illegalOf(input logic [31:0] i);
        return !(i[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                7'h13, 7'h1B, 7'h33, 7'h3B, 7'h0F});
    endfunction

    // Immediates rebuilt by weighting each field with its place value.
    function automatic logic [63:0] immOf(input logic [31:0] i);
        int     s;
        longint r;
        s = i;
        case (fmtOf(i))
            F_I: r = longint'(s >>> 20);
            F_S: r = longint'(s >>> 25) * 32 + longint'(i[11:7]);
            F_B: r = longint'(s >>> 31) * 4096 + longint'(i[7]) * 2048 +
                     longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            F_U: r = longint'(s >>> 12) * 4096;
            F_J: r = longint'(s >>> 31) * 1048576 + longint'(i[19:12]) * 4096 +
                     longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic bit useRs1(input logic [31:0] i);
        return fmtOf(i) inside {F_R, F_I, F_S, F_B};
    endfunction

    function automatic bit useRs2(input logic [31:0] i);
        return fmtOf(i) inside {F_R, F_S, F_B};
    endfunction

    function automatic bit modelLoadUse();
        return m_valid && bus.exe_valid && bus.exe_is_load && (bus.exe_rd != 5'd0) &&
               ((useRs1(m_instr) && m_instr[19:15] == bus.exe_rd) ||
                (useRs2(m_instr) && m_instr[24:20] == bus.exe_rd));
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelUpdate();
        if (!rst) begin
            m_valid = 1'b0;
            m_pc    = '0;
            m_instr = NOP;
        end else if (bus.exe_redirect) begin
            m_valid = 1'b0;
            m_instr = NOP;
        end else if (!(bus.exe_stall || modelLoadUse())) begin
            m_valid = bus.if_ready;
            m_pc    = bus.if_pc;
            m_instr = bus.if_instr;
        end
    endtask

    task automatic compareModel();
        int          f;
        bit          en;
        bit          lu;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
        logic [6:0]  op;
        f  = fmtOf(m_instr);
        op = m_instr[6:0];
        lu = modelLoadUse();
        en = m_valid && !lu && !bus.exe_redirect;
        a1 = useRs1(m_instr) ? m_instr[19:15] : 5'd0;
        a2 = useRs2(m_instr) ? m_instr[24:20] : 5'd0;
        rd = (en && (f inside {F_R, F_I, F_U, F_J})) ? m_instr[11:7] : 5'd0;
        checkOutput("raddr1", 64'(bus.rf_raddr1), 64'(a1));
        checkOutput("raddr2", 64'(bus.rf_raddr2), 64'(a2));
        checkOutput("stall", 64'(bus.id_stall),
                    64'(rst && (bus.exe_stall || lu) && !bus.exe_redirect));
        checkOutput("valid", 64'(bus.id_valid), 64'(en));
        checkOutput("pc", bus.id_pc, m_pc);
        checkOutput("instr", 64'(bus.id_instr), 64'(m_instr));
        checkOutput("rs1_val", bus.id_rs1_val, regs[a1]);
        checkOutput("rs2_val", bus.id_rs2_val, regs[a2]);
        checkOutput("imm", bus.id_imm, immOf(m_instr));
        checkOutput("rd", 64'(bus.id_rd), 64'(rd));
        checkOutput("funct3", 64'(bus.id_funct3), 64'(m_instr[14:12]));
        checkOutput("funct7_5", 64'(bus.id_funct7_5), 64'(m_instr[30]));
        checkOutput("reg_write", 64'(bus.id_reg_write), 64'(rd != 5'd0));
        checkOutput("mem_read", 64'(bus.id_mem_read), 64'(en && op == 7'h03));
        checkOutput("mem_write", 64'(bus.id_mem_write), 64'(en && op == 7'h23));
        checkOutput("branch", 64'(bus.id_branch), 64'(en && op == 7'h63));
        checkOutput("jump", 64'(bus.id_jump), 64'(en && (op == 7'h6F || op == 7'h67)));
        checkOutput("word", 64'(bus.id_word), 64'(en && (op == 7'h1B || op == 7'h3B)));
        checkOutput("alu_imm", 64'(bus.id_alu_imm), 64'(en && (f inside {F_I, F_U, F_S})));
        checkOutput("illegal", 64'(bus.id_illegal), 64'(en && illegalOf(m_instr)));
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        compareModel();
    endtask

    task automatic applyStimulus(input logic [63:0] pc, input logic [31:0] instr,
                                 input logic ready, input logic redirect,
                                 input logic ev, input logic eload,
                                 input logic [4:0] erd, input logic estall);
        bus.if_pc        = pc;
        bus.if_instr     = instr;
        bus.if_ready     = ready;
        bus.exe_redirect = redirect;
        bus.exe_valid    = ev;
        bus.exe_is_load  = eload;
        bus.exe_rd       = erd;
        bus.exe_stall    = estall;
    endtask

    function automatic logic [31:0] randInstr();
        logic [6:0]  ops [13];
        logic [31:0] r;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                7'h13, 7'h1B, 7'h33, 7'h3B, 7'h0F, 7'h73};
        r = $urandom();
        if ($urandom_range(0, 9) != 0) begin
            r[6:0]   = ops[$urandom_range(0, 12)];
            r[19:15] = 5'($urandom_range(0, 4));
            r[24:20] = 5'($urandom_range(0, 4));
        end
        return r;
    endfunction

    initial begin
        for (int k = 0; k < 32; k++) regs[k] = (k == 0) ? 64'd0 : {$urandom(), $urandom()};

        // Reset held with random inputs.
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus({$urandom(), $urandom()}, $urandom(), ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 1) == 1));
            tick();
            checkOutput("rst_valid", 64'(bus.id_valid), 64'd0);
            checkOutput("rst_stall", 64'(bus.id_stall), 64'd0);
            checkOutput("rst_instr", 64'(bus.id_instr), 64'h13);
        end

        rst = 1'b1;
        applyStimulus(64'h8000_0000, 32'hFFF0_0093, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("rel_valid", 64'(bus.id_valid), 64'd1);
        checkOutput("rel_imm", bus.id_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("rel_rd", 64'(bus.id_rd), 64'd1);
        checkOutput("rel_regw", 64'(bus.id_reg_write), 64'd1);

        // Load-use against rs2 of add x3,x1,x2.
        applyStimulus(64'h8000_0004, 32'h0020_81B3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(64'h8000_0008, 32'h0010_0093, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0);
        tick();
        checkOutput("lu_stall", 64'(bus.id_stall), 64'd1);
        checkOutput("lu_valid", 64'(bus.id_valid), 64'd0);
        applyStimulus(64'h8000_0008, 32'h0010_0093, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("lu_rel_valid", 64'(bus.id_valid), 64'd1);
        checkOutput("lu_rel_stall", 64'(bus.id_stall), 64'd0);
        checkOutput("lu_rel_pc", bus.id_pc, 64'h8000_0004);
        tick();

        // x0 load destination and LUI with matching rs field never stall.
        applyStimulus(64'h8000_000C, 32'h0020_81B3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(64'h8000_0010, 32'h0001_02B7, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
        #1;
        checkOutput("x0_stall", 64'(bus.id_stall), 64'd0);
        tick();
        applyStimulus(64'h8000_0014, 32'h0020_81B3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0);
        #1;
        checkOutput("lui_stall", 64'(bus.id_stall), 64'd0);
        checkOutput("lui_valid", 64'(bus.id_valid), 64'd1);

        // Flush together with downstream stall.
        applyStimulus(64'h8000_0014, 32'h0020_81B3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        #1;
        checkOutput("fl_stall", 64'(bus.id_stall), 64'd0);
        checkOutput("fl_valid", 64'(bus.id_valid), 64'd0);
        tick();
        checkOutput("fl_instr", 64'(bus.id_instr), 64'h13);
        checkOutput("fl_valid2", 64'(bus.id_valid), 64'd0);

        applyStimulus(64'h8000_0100, 32'hFE00_0EE3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("beq_imm", bus.id_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("beq_branch", 64'(bus.id_branch), 64'd1);
        checkOutput("beq_rd", 64'(bus.id_rd), 64'd0);
        applyStimulus(64'h8000_0104, 32'hFE51_3C23, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("sd_imm", bus.id_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        checkOutput("sd_mem_write", 64'(bus.id_mem_write), 64'd1);
        applyStimulus(64'h8000_0108, 32'h0010_00EF, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("jal_imm", bus.id_imm, 64'd2048);
        applyStimulus(64'h8000_010C, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("zero_illegal", 64'(bus.id_illegal), 64'd1);
        checkOutput("zero_regw", 64'(bus.id_reg_write), 64'd0);
        checkOutput("zero_mem_read", 64'(bus.id_mem_read), 64'd0);
        applyStimulus(64'h8000_0110, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("ecall_illegal", 64'(bus.id_illegal), 64'd1);

        // Randomized traffic; exe_rd is biased toward the latched source registers.
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 63) != 0);
            bus.if_pc        = {$urandom(), $urandom()};
            bus.if_instr     = randInstr();
            bus.if_ready     = ($urandom_range(0, 3) != 0);
            bus.exe_redirect = ($urandom_range(0, 9) == 0);
            bus.exe_stall    = ($urandom_range(0, 5) == 0);
            bus.exe_valid    = ($urandom_range(0, 1) == 1);
            bus.exe_is_load  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1)
                bus.exe_rd = ($urandom_range(0, 1) == 1) ? m_instr[19:15] : m_instr[24:20];
            else
                bus.exe_rd = 5'($urandom_range(0, 7));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
